// File: rtl/md_unit_if.sv
// Operand/result bundle between the execute stage and the multiply/divide unit.
// The execute stage is the master; md_unit is the slave.
interface md_unit_if;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start,
        output md_op,
        output rs_val,
        output rt_val,
        input  busy,
        input  hi,
        input  lo
    );

    modport slave (
        input  start,
        input  md_op,
        input  rs_val,
        input  rt_val,
        output busy,
        output hi,
        output lo
    );
endinterface

// File: rtl/md_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit with HI/LO registers for the execute stage.
// Results are computed at launch and held privately until the busy period retires.
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic      clk,
    input  logic      reset_n,
    md_unit_if.slave  bus
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W_RAW  = $clog2(MAX_CYCLES + 1);
    localparam int CNT_W      = (CNT_W_RAW < 4) ? 4 : CNT_W_RAW;

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

    localparam logic [2:0] OP_NONE  = 3'd0;
    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q,    cnt_d;
    logic [31:0]       hi_q,     hi_d;
    logic [31:0]       lo_q,     lo_d;
    logic [31:0]       res_hi_q, res_hi_d;
    logic [31:0]       res_lo_q, res_lo_d;
    logic              dz_q,     dz_d;
    logic              busy_q,   busy_d;

    logic              launch_s;
    logic [63:0]       result_s;

    function automatic logic is_md_op(input logic [2:0] op);
        logic r;
        case (op)
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: r = 1'b1;
            default:                            r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic is_div_op(input logic [2:0] op);
        logic r;
        case (op)
            OP_DIV, OP_DIVU: r = 1'b1;
            default:         r = 1'b0;
        endcase
        return r;
    endfunction

    // Signed division works on magnitudes so that 0x80000000 / -1 wraps to 0x80000000
    // and never hits an overflowing signed divide.
    function automatic logic [63:0] md_compute(input logic [2:0] op,
                                               input logic [31:0] a,
                                               input logic [31:0] b);
        logic [63:0] ext_a;
        logic [63:0] ext_b;
        logic [31:0] mag_a;
        logic [31:0] mag_b;
        logic [31:0] den;
        logic [31:0] quo;
        logic [31:0] rem;
        logic [63:0] r;
        ext_a = 64'd0;
        ext_b = 64'd0;
        mag_a = 32'd0;
        mag_b = 32'd0;
        den   = 32'd1;
        quo   = 32'd0;
        rem   = 32'd0;
        r     = 64'd0;
        case (op)
            OP_MULT: begin
                ext_a = {{32{a[31]}}, a};
                ext_b = {{32{b[31]}}, b};
                r     = ext_a * ext_b;
            end
            OP_MULTU: begin
                ext_a = {32'd0, a};
                ext_b = {32'd0, b};
                r     = ext_a * ext_b;
            end
            OP_DIV: begin
                mag_a = a[31] ? (32'd0 - a) : a;
                mag_b = b[31] ? (32'd0 - b) : b;
                den   = (mag_b == 32'd0) ? 32'd1 : mag_b;
                quo   = mag_a / den;
                rem   = mag_a % den;
                quo   = (a[31] ^ b[31]) ? (32'd0 - quo) : quo;
                rem   = a[31] ? (32'd0 - rem) : rem;
                r     = {rem, quo};
            end
            OP_DIVU: begin
                den = (b == 32'd0) ? 32'd1 : b;
                quo = a / den;
                rem = a % den;
                r   = {rem, quo};
            end
            default: r = 64'd0;
        endcase
        return r;
    endfunction

    assign launch_s = bus.start && is_md_op(bus.md_op);
    assign result_s = md_compute(bus.md_op, bus.rs_val, bus.rt_val);

    // State and datapath registers, all cleared by the asynchronous reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            cnt_q    <= CNT_ZERO;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
            res_hi_q <= 32'd0;
            res_lo_q <= 32'd0;
            dz_q     <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            res_hi_q <= res_hi_d;
            res_lo_q <= res_lo_d;
            dz_q     <= dz_d;
            busy_q   <= busy_d;
        end
    end

    // Next-state logic: launch from IDLE, retire when the counter reaches one.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (launch_s) begin
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (cnt_q == CNT_ONE) begin
                    state_d = IDLE;
                end else begin
                    state_d = RUN;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath: capture at launch, count down in RUN, commit HI/LO at retire.
    always_comb begin
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        res_hi_d = res_hi_q;
        res_lo_d = res_lo_q;
        dz_d     = dz_q;
        case (state_q)
            IDLE: begin
                if (launch_s) begin
                    res_hi_d = result_s[63:32];
                    res_lo_d = result_s[31:0];
                    dz_d     = is_div_op(bus.md_op) && (bus.rt_val == 32'd0);
                    cnt_d    = is_div_op(bus.md_op) ? DIV_LOAD : MULT_LOAD;
                end else if (!bus.start && (bus.md_op == OP_MTHI)) begin
                    hi_d = bus.rs_val;
                end else if (!bus.start && (bus.md_op == OP_MTLO)) begin
                    lo_d = bus.rs_val;
                end else begin
                    cnt_d = cnt_q;
                end
            end
            RUN: begin
                if (cnt_q == CNT_ONE) begin
                    cnt_d = CNT_ZERO;
                    if (!dz_q) begin
                        hi_d = res_hi_q;
                        lo_d = res_lo_q;
                    end else begin
                        hi_d = hi_q;
                        lo_d = lo_q;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: cnt_d = CNT_ZERO;
        endcase
    end

    // Output decode: busy registered alongside the state it mirrors.
    always_comb begin
        if (state_d == RUN) begin
            busy_d = 1'b1;
        end else begin
            busy_d = 1'b0;
        end
    end

    assign bus.busy = busy_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;

    logic unused_s;
    assign unused_s = (OP_NONE == 3'd0);

endmodule

// File: tb/tb_md_unit.sv
// Directed self-checking bench for md_unit: arithmetic, busy timing, HI/LO moves,
// ignored commands while busy, divide by zero and asynchronous reset mid-operation.
module tb_md_unit;

    localparam int MC = 5;
    localparam int DC = 10;

    logic clk;
    logic reset_n;
    int   n_checks;
    int   n_fail;

    md_unit_if bus ();

    md_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    // Caller is at a negedge. Launches op, checks every busy cycle, then the retire values.
    task automatic run_op(input string tag, input logic [2:0] op,
                          input logic [31:0] a, input logic [31:0] b, input int n,
                          input logic [31:0] pre_hi, input logic [31:0] pre_lo,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                          input bit inject);
        bus.start  = 1'b1;
        bus.md_op  = op;
        bus.rs_val = a;
        bus.rt_val = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.md_op = 3'd0;
        for (int i = 1; i <= n; i++) begin
            @(negedge clk);
            check({tag, "_busy"}, {31'd0, bus.busy}, 32'd1);
            check({tag, "_hold_hi"}, bus.hi, pre_hi);
            check({tag, "_hold_lo"}, bus.lo, pre_lo);
            if (inject) begin
                if (i == 2) begin
                    bus.start  = 1'b1;
                    bus.md_op  = 3'd3;
                    bus.rs_val = 32'd100;
                    bus.rt_val = 32'd3;
                end else if (i == 3) begin
                    bus.start  = 1'b0;
                    bus.md_op  = 3'd6;
                    bus.rs_val = 32'h0000DEAD;
                end else if (i == 4) begin
                    bus.md_op = 3'd0;
                end
            end
        end
        @(negedge clk);
        check({tag, "_idle"}, {31'd0, bus.busy}, 32'd0);
        check({tag, "_hi"}, bus.hi, exp_hi);
        check({tag, "_lo"}, bus.lo, exp_lo);
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        reset_n    = 1'b0;
        bus.start  = 1'b0;
        bus.md_op  = 3'd0;
        bus.rs_val = 32'd0;
        bus.rt_val = 32'd0;

        #3;
        check("reset_busy", {31'd0, bus.busy}, 32'd0);
        check("reset_hi", bus.hi, 32'd0);
        check("reset_lo", bus.lo, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        run_op("mult_neg", 3'd1, 32'hFFFFFFFD, 32'd5, MC,
               32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0);
        run_op("multu", 3'd2, 32'hFFFFFFFF, 32'd2, MC,
               32'hFFFFFFFF, 32'hFFFFFFF1, 32'h00000001, 32'hFFFFFFFE, 1'b0);
        run_op("mult_m1x2", 3'd1, 32'hFFFFFFFF, 32'd2, MC,
               32'h00000001, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0);
        run_op("div_neg", 3'd3, 32'hFFFFFFF9, 32'd2, DC,
               32'hFFFFFFFF, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
        run_op("divu", 3'd4, 32'd7, 32'd2, DC,
               32'hFFFFFFFF, 32'hFFFFFFFD, 32'd1, 32'd3, 1'b0);
        run_op("div_ovf", 3'd3, 32'h80000000, 32'hFFFFFFFF, DC,
               32'd1, 32'd3, 32'd0, 32'h80000000, 1'b0);

        bus.md_op  = 3'd5;
        bus.rs_val = 32'h12345678;
        @(negedge clk);
        check("mthi_hi", bus.hi, 32'h12345678);
        check("mthi_lo", bus.lo, 32'h80000000);
        bus.md_op  = 3'd6;
        bus.rs_val = 32'h9ABCDEF0;
        @(negedge clk);
        check("mtlo_lo", bus.lo, 32'h9ABCDEF0);
        check("mtlo_hi", bus.hi, 32'h12345678);

        bus.start  = 1'b1;
        bus.md_op  = 3'd5;
        bus.rs_val = 32'h55555555;
        @(negedge clk);
        check("start_mthi_busy", {31'd0, bus.busy}, 32'd0);
        check("start_mthi_hi", bus.hi, 32'h12345678);
        bus.md_op = 3'd7;
        @(negedge clk);
        check("start_rsvd_busy", {31'd0, bus.busy}, 32'd0);
        bus.start = 1'b0;
        bus.md_op = 3'd0;

        run_op("divu_zero", 3'd4, 32'd99, 32'd0, DC,
               32'h12345678, 32'h9ABCDEF0, 32'h12345678, 32'h9ABCDEF0, 1'b0);
        run_op("mult_inject", 3'd1, 32'd6, 32'd7, MC,
               32'h12345678, 32'h9ABCDEF0, 32'd0, 32'd42, 1'b1);
        @(negedge clk);
        check("inject_quiet_busy", {31'd0, bus.busy}, 32'd0);
        check("inject_quiet_lo", bus.lo, 32'd42);

        bus.start  = 1'b1;
        bus.md_op  = 3'd3;
        bus.rs_val = 32'd100;
        bus.rt_val = 32'd7;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.md_op = 3'd0;
        repeat (4) @(negedge clk);
        check("pre_rst_busy", {31'd0, bus.busy}, 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("rst_mid_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_mid_hi", bus.hi, 32'd0);
        check("rst_mid_lo", bus.lo, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("post_rst_busy", {31'd0, bus.busy}, 32'd0);

        run_op("mult_3x4", 3'd1, 32'd3, 32'd4, MC,
               32'd0, 32'd0, 32'd0, 32'd12, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
